// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response link shared by fetch, data and memory ports
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              done;

  modport master (output req, we, addr, wdata, input rdata, done);
  modport slave  (input req, we, addr, wdata, output rdata, done);
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - IF/DM arbiter for one single-ported memory, DM priority with IF anti-starvation
// Optional ack timeout/abort enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    if_port,
  mem_port_arbiter_if.slave    dm_port,
  mem_port_arbiter_if.master   mem_port,
  output logic                 err,
  output logic                 stall_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM, DONE} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIM);

  state_t            state, state_nxt;
  logic [3:0]        starve_cnt;
  logic              owner_dm;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              if_win, dm_win, busy, ack, abort_now, if_done;

`ifdef ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt;
  logic          aborted;
`endif

  always_comb begin
    if_win = if_port.req && (!dm_port.req || (starve_cnt >= LIM));
    dm_win = dm_port.req && !if_win;
    busy   = (state == BUSY_IF) || (state == BUSY_DM);
    ack    = busy && mem_port.done;
    abort_now = 1'b0;
`ifdef ARB_TIMEOUT_EN
    // A late ack in the expiry cycle still wins over the abort.
    abort_now = busy && !mem_port.done && (tcnt == TMAX);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (if_win)      state_nxt = BUSY_IF;
        else if (dm_win) state_nxt = BUSY_DM;
      end
      BUSY_IF, BUSY_DM: if (ack || abort_now) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_done         = (state == DONE) && !owner_dm;
    mem_port.req    = busy;
    mem_port.we     = we_q;
    mem_port.addr   = addr_q;
    mem_port.wdata  = wdata_q;
    if_port.done    = if_done;
    if_port.rdata   = if_rdata_q;
    dm_port.done    = (state == DONE) && owner_dm;
    dm_port.rdata   = dm_rdata_q;
    stall_o         = if_port.req && !if_done;
`ifdef ARB_TIMEOUT_EN
    err             = (state == DONE) && aborted;
`else
    err             = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      owner_dm   <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      if (state == IDLE) begin
        if (if_win) begin
          addr_q     <= if_port.addr;
          we_q       <= 1'b0;
          wdata_q    <= '0;
          owner_dm   <= 1'b0;
          starve_cnt <= '0;
        end else if (dm_win) begin
          addr_q   <= dm_port.addr;
          we_q     <= dm_port.we;
          wdata_q  <= dm_port.wdata;
          owner_dm <= 1'b1;
          if (if_port.req && (starve_cnt != 4'hF)) starve_cnt <= starve_cnt + 4'd1;
        end
      end
      if (ack && !we_q) begin
        if (owner_dm) dm_rdata_q <= mem_port.rdata;
        else          if_rdata_q <= mem_port.rdata;
      end
      if (abort_now) begin
        if (owner_dm) dm_rdata_q <= '0;
        else          if_rdata_q <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt    <= '0;
      aborted <= 1'b0;
    end else begin
      if (state == IDLE) begin
        tcnt    <= '0;
        aborted <= 1'b0;
      end else if (busy && !mem_port.done) begin
        tcnt <= tcnt + 1'b1;
      end
      if (abort_now) aborted <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector and sequence bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic rst;
  logic err;
  logic stall_o;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) if_bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) dm_bus ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(3), .TIMEOUT(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .if_port  (if_bus),
    .dm_port  (dm_bus),
    .mem_port (mem_bus),
    .err      (err),
    .stall_o  (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        ack;
    logic [31:0] mrdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_ifd;
    logic [31:0] e_ifr;
    logic        e_dmd;
    logic [31:0] e_dmr;
    logic        e_stall;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int grants;
    int cyc;
    int dones;
    int phase, hi1, gap, gapdone;
    logic prev_req;
    logic exp_dm;

    rst = 1'b0;
    if_bus.req = 0; if_bus.we = 0; if_bus.addr = 0; if_bus.wdata = 0;
    dm_bus.req = 0; dm_bus.we = 0; dm_bus.addr = 0; dm_bus.wdata = 0;
    mem_bus.rdata = 0; mem_bus.done = 0;

    tbl[0]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h10, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tbl[1]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tbl[2]  = tbl[1];
    tbl[3]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h30F40A00, 1'b1, 1'b0, 32'h20, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    tbl[4]  = '{1'b1, 32'h20, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h20, 32'h0,        1'b1, 32'h30F40A00, 1'b0, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 32'h44, 32'h0,        1'b1, 32'h11223344, 1'b1, 1'b0, 32'h44, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'h0,        1'b0};
    tbl[8]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h44, 32'h0,        1'b0, 32'h30F40A00, 1'b1, 32'h11223344, 1'b0};
    tbl[9]  = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h44, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'h11223344, 1'b0};
    tbl[10] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 32'h0,        1'b0, 1'b0, 32'h44, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'h11223344, 1'b0};
    tbl[11] = '{1'b0, 32'h0,  1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b1, 32'hFFFF0000, 1'b1, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 32'h30F40A00, 1'b0, 32'h11223344, 1'b0};
    tbl[12] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 32'h30F40A00, 1'b1, 32'h11223344, 1'b0};
    tbl[13] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h5555,     1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 32'h30F40A00, 1'b0, 32'h11223344, 1'b0};
    tbl[14] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 32'h30F40A00, 1'b0, 32'h11223344, 1'b0};
    tbl[15] = '{1'b1, 32'h60, 1'b1, 1'b0, 32'h90, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1'b0, 32'h30F40A00, 1'b0, 32'h11223344, 1'b1};
    tbl[16] = '{1'b1, 32'h60, 1'b1, 1'b0, 32'h90, 32'h0,        1'b1, 32'hABCD0001, 1'b1, 1'b0, 32'h90, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'h11223344, 1'b1};
    tbl[17] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h90, 32'h0,        1'b0, 32'h30F40A00, 1'b1, 32'hABCD0001, 1'b1};
    tbl[18] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h90, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'hABCD0001, 1'b1};
    tbl[19] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,  32'h0,        1'b1, 32'h0BAD0BAD, 1'b1, 1'b0, 32'h60, 32'h0,        1'b0, 32'h30F40A00, 1'b0, 32'hABCD0001, 1'b1};
    tbl[20] = '{1'b1, 32'h60, 1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h60, 32'h0,        1'b1, 32'h0BAD0BAD, 1'b0, 32'hABCD0001, 1'b0};
    tbl[21] = '{1'b0, 32'h0,  1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 32'h60, 32'h0,        1'b0, 32'h0BAD0BAD, 1'b0, 32'hABCD0001, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    check("reset mem_req",  32'(mem_bus.req),  32'h0);
    check("reset mem_addr", mem_bus.addr,      32'h0);
    check("reset if_done",  32'(if_bus.done),  32'h0);
    check("reset dm_rdata", dm_bus.rdata,      32'h0);
    check("reset err",      32'(err),          32'h0);
    check("reset stall_o",  32'(stall_o),      32'h0);
    tick();
    rst = 1'b1;

    // Asynchronous reset in the middle of a DM access
    dm_bus.req = 1; dm_bus.addr = 32'h300;
    tick();
    check("pre-reset mem_req", 32'(mem_bus.req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async reset mem_req",  32'(mem_bus.req), 32'h0);
    check("async reset dm_done",  32'(dm_bus.done), 32'h0);
    check("async reset stall_o",  32'(stall_o),     32'h0);
    check("async reset mem_addr", mem_bus.addr,     32'h0);
    dm_bus.req = 0; dm_bus.addr = 0;
    if_bus.req = 1; if_bus.addr = 32'h10;
    tick();
    rst = 1'b1;
    tick();
    check("post-reset grant mem_req",  32'(mem_bus.req), 32'h1);
    check("post-reset grant mem_addr", mem_bus.addr,     32'h10);
    mem_bus.done = 1; mem_bus.rdata = 32'h0;
    tick();
    mem_bus.done = 0;
    check("post-reset if_done", 32'(if_bus.done), 32'h1);
    if_bus.req = 0; if_bus.addr = 0;
    tick();

    // Table-driven single-cycle vectors
    for (int i = 0; i < 22; i++) begin
      if_bus.req    = tbl[i].if_req;
      if_bus.addr   = tbl[i].if_addr;
      dm_bus.req    = tbl[i].dm_req;
      dm_bus.we     = tbl[i].dm_we;
      dm_bus.addr   = tbl[i].dm_addr;
      dm_bus.wdata  = tbl[i].dm_wdata;
      mem_bus.done  = tbl[i].ack;
      mem_bus.rdata = tbl[i].mrdata;
      @(negedge clk);
      check($sformatf("row %0d mem_req", i),   32'(mem_bus.req),  32'(tbl[i].e_req));
      check($sformatf("row %0d mem_we", i),    32'(mem_bus.we),   32'(tbl[i].e_we));
      check($sformatf("row %0d mem_addr", i),  mem_bus.addr,      tbl[i].e_addr);
      check($sformatf("row %0d mem_wdata", i), mem_bus.wdata,     tbl[i].e_wdata);
      check($sformatf("row %0d if_done", i),   32'(if_bus.done),  32'(tbl[i].e_ifd));
      check($sformatf("row %0d if_rdata", i),  if_bus.rdata,      tbl[i].e_ifr);
      check($sformatf("row %0d dm_done", i),   32'(dm_bus.done),  32'(tbl[i].e_dmd));
      check($sformatf("row %0d dm_rdata", i),  dm_bus.rdata,      tbl[i].e_dmr);
      check($sformatf("row %0d stall_o", i),   32'(stall_o),      32'(tbl[i].e_stall));
      check($sformatf("row %0d err", i),       32'(err),          32'h0);
      tick();
    end
    mem_bus.done = 0; mem_bus.rdata = 0;

    // Contention: starve counter is 0 here, so order is DM DM DM IF DM DM DM IF
    if_bus.req = 1; if_bus.addr = 32'h40;
    dm_bus.req = 1; dm_bus.we = 1; dm_bus.addr = 32'h100; dm_bus.wdata = 32'hDEADBEEF;
    grants = 0; cyc = 0; prev_req = 0;
    while (grants < 8 && cyc < 200) begin
      @(negedge clk);
      if (mem_bus.req && !prev_req) begin
        exp_dm = ((grants % 4) != 3);
        check($sformatf("grant %0d is_dm", grants), 32'(mem_bus.we), 32'(exp_dm));
        check($sformatf("grant %0d addr", grants), mem_bus.addr, exp_dm ? 32'h100 : 32'h40);
        check($sformatf("grant %0d wdata", grants), mem_bus.wdata, exp_dm ? 32'hDEADBEEF : 32'h0);
        grants++;
      end
      prev_req = mem_bus.req;
      mem_bus.done = mem_bus.req;
      tick();
      cyc++;
    end
    check("contention grant count", 32'(grants), 32'd8);
    if_bus.req = 0; dm_bus.req = 0; dm_bus.we = 0; dm_bus.wdata = 0; mem_bus.done = 0;
    tick();
    tick();

    // Hold stability while dm_addr changes and ack is late
    dm_bus.req = 1; dm_bus.addr = 32'h100;
    tick();
    dm_bus.addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      mem_bus.done  = (k == 5);
      mem_bus.rdata = 32'h77;
      @(negedge clk);
      check($sformatf("hold %0d mem_req", k),  32'(mem_bus.req), 32'h1);
      check($sformatf("hold %0d mem_addr", k), mem_bus.addr,     32'h100);
      tick();
    end
    mem_bus.done = 0;
    dones = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dm_bus.done) begin
        dones++;
        check("hold dm_rdata", dm_bus.rdata, 32'h77);
        dm_bus.req = 0;
      end
      tick();
    end
    check("hold dm_done count", 32'(dones), 32'd1);
    dm_bus.req = 0; dm_bus.addr = 0;

    // Back-to-back: ack in first cycle, requester keeps dm_req high (DONE then IDLE between grants)
    dm_bus.req = 1; dm_bus.addr = 32'h104;
    phase = 0; hi1 = 0; gap = 0; gapdone = 0; cyc = 0;
    while (phase < 3 && cyc < 20) begin
      @(negedge clk);
      case (phase)
        0: if (mem_bus.req) begin phase = 1; hi1 = 1; end
        1: if (mem_bus.req) hi1++;
           else begin phase = 2; gap = 1; gapdone += int'(dm_bus.done); end
        default: if (mem_bus.req) phase = 3;
                 else begin gap++; gapdone += int'(dm_bus.done); end
      endcase
      mem_bus.done = mem_bus.req;
      tick();
      cyc++;
    end
    dm_bus.req = 0; mem_bus.done = 0;
    check("b2b reached second grant", 32'(phase), 32'd3);
    check("b2b first mem_req length", 32'(hi1),    32'd1);
    check("b2b low cycles between",   32'(gap),    32'd2);
    check("b2b done cycles in gap",   32'(gapdone), 32'd1);
    tick();
    tick();

`ifdef ARB_TIMEOUT_EN
    // Timeout: no ack ever arrives
    dm_bus.req = 1; dm_bus.we = 0; dm_bus.addr = 32'h500;
    tick();
    cyc = 0;
    while (mem_bus.req && cyc < 40) begin
      cyc++;
      tick();
    end
    check("timeout mem_req cycles", 32'(cyc), 32'd16);
    #1;
    check("timeout dm_done",  32'(dm_bus.done), 32'h1);
    check("timeout err",      32'(err),         32'h1);
    check("timeout dm_rdata", dm_bus.rdata,     32'h0);
    dm_bus.req = 0;
    tick();
    if_bus.req = 1; if_bus.addr = 32'h600;
    tick();
    check("after timeout grant", 32'(mem_bus.req), 32'h1);
    mem_bus.done = 1; mem_bus.rdata = 32'h1234;
    tick();
    mem_bus.done = 0;
    check("after timeout if_done", 32'(if_bus.done), 32'h1);
    check("after timeout err",     32'(err),         32'h0);
    if_bus.req = 0;
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
